call_panel: RTL and testbench

Front-end panel block for the elevator controller. It drives the controller's request side and consumes its status side. It synchronizes and debounces raw car (`eb`), hall-up and hall-down push buttons, then emits single-cycle request pulses on `in_eb`/`in_up`/`in_down`. It also drives button lamps from the controller's pending-request vectors, and turns the one-hot floor vector `q` into a binary floor indicator with an arrival chime.

---
 rtl/elevator_pkg.sv | 15 +
 rtl/button_debounce.sv | 63 ++++++
 rtl/call_panel.sv | 212 +++++++++++++++++++++
 tb/tb_call_panel.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator front-end panel.
//   FLOORS_DEFAULT : default number of floors (width of every request vector)
//   FLOOR_W        : width of a binary floor index for the default floor count
//   chime_state_e  : arrival chime FSM states
package elevator_pkg;

    localparam int FLOORS_DEFAULT = 8;
    localparam int FLOOR_W        = $clog2(FLOORS_DEFAULT);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RING = 1'b1
    } chime_state_e;

endpackage

// File: rtl/button_debounce.sv
// One push-button input conditioner: a 2-flop synchronizer followed by a
// debounce counter that only accepts a new level after it has been seen for
// DEBOUNCE_CYCLES consecutive synchronized cycles.
// Ports:
//   clk     : rising-edge clock
//   reset   : asynchronous active-low reset
//   btn_raw : raw asynchronous button level (1 = pressed)
//   rise    : one-cycle registered pulse when a press (0->1) is accepted
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q,  sync_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             level_q, level_d;
    logic             rise_q,  rise_d;

    // Synchronizer chain, disagreement counter, accepted level and rise flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    // Count cycles the synchronized level disagrees with the accepted one;
    // the edge that would make the count reach DEBOUNCE_CYCLES flips the level.
    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
                rise_d  = sync_q[1];
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/call_panel.sv
// Elevator front-end panel: debounces car / hall-up / hall-down buttons into
// single-cycle request pulses, drives button lamps from the controller's
// pending vectors plus a short local hold, and decodes the one-hot floor
// vector into a binary indicator with an arrival chime.
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   btn_eb/btn_up/btn_down     : raw buttons, FLOORS bits each
//   in_eb/in_up/in_down        : one-cycle request pulses to the controller
//   q                          : controller current floor (one-hot)
//   q_eb/q_up/q_down           : controller pending-request vectors
//   lamp_eb/lamp_up/lamp_down  : button lamps
//   floor_bin, floor_valid     : binary floor index and one-hot validity
//   chime                      : arrival chime
module call_panel
    import elevator_pkg::*;
#(
    parameter int FLOORS          = FLOORS_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACK_CYCLES      = 4,
    parameter int CHIME_CYCLES    = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [FLOORS-1:0]         btn_eb,
    input  logic [FLOORS-1:0]         btn_up,
    input  logic [FLOORS-1:0]         btn_down,
    output logic [FLOORS-1:0]         in_eb,
    output logic [FLOORS-1:0]         in_up,
    output logic [FLOORS-1:0]         in_down,
    input  logic [FLOORS-1:0]         q,
    input  logic [FLOORS-1:0]         q_eb,
    input  logic [FLOORS-1:0]         q_up,
    input  logic [FLOORS-1:0]         q_down,
    output logic [FLOORS-1:0]         lamp_eb,
    output logic [FLOORS-1:0]         lamp_up,
    output logic [FLOORS-1:0]         lamp_down,
    output logic [$clog2(FLOORS)-1:0] floor_bin,
    output logic                      floor_valid,
    output logic                      chime
);

    localparam int NB = 3 * FLOORS;
    localparam int FW = $clog2(FLOORS);
    localparam int AW = $clog2(ACK_CYCLES + 1);
    localparam int CW = $clog2(CHIME_CYCLES + 1);

    localparam logic [AW-1:0] ACK_LOAD   = AW'(ACK_CYCLES - 1);
    localparam logic [CW-1:0] CHIME_LOAD = CW'(CHIME_CYCLES);

    // No "up" call exists on the top floor and no "down" call on the bottom.
    localparam logic [FLOORS-1:0] EB_OK   = {FLOORS{1'b1}};
    localparam logic [FLOORS-1:0] UP_OK   = {1'b0, {(FLOORS - 1){1'b1}}};
    localparam logic [FLOORS-1:0] DOWN_OK = {{(FLOORS - 1){1'b1}}, 1'b0};
    localparam logic [NB-1:0]     BTN_OK  = {DOWN_OK, UP_OK, EB_OK};

    function automatic logic is_onehot(input logic [FLOORS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    function automatic logic [FW-1:0] onehot_index(input logic [FLOORS-1:0] v);
        logic [FW-1:0] idx;
        idx = '0;
        for (int i = 0; i < FLOORS; i++) begin
            idx = idx | (v[i] ? FW'(i) : '0);
        end
        return idx;
    endfunction

    logic [NB-1:0]          btn_all_s;
    logic [NB-1:0]          req_all_s;
    logic [NB-1:0]          rise_s;
    logic [NB-1:0]          lamp_s;
    logic [NB-1:0]          pulse_q, pulse_d;
    logic [NB-1:0]          hold_q,  hold_d;
    logic [NB-1:0][AW-1:0]  ack_cnt_q, ack_cnt_d;

    logic [FW-1:0]          floor_bin_q, floor_bin_d;
    logic                   floor_valid_q, floor_valid_d;
    logic [FW-1:0]          last_bin_q, last_bin_d;
    logic                   have_last_q, have_last_d;
    logic                   arrival_s;
    chime_state_e           state_q, state_d;
    logic [CW-1:0]          chime_cnt_q, chime_cnt_d;

    assign btn_all_s = {btn_down, btn_up, btn_eb};
    assign req_all_s = {q_down, q_up, q_eb};

    for (genvar b = 0; b < NB; b++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .btn_raw(btn_all_s[b]),
            .rise   (rise_s[b])
        );
    end

    // Request pulses, lamp hold flags and their acknowledge timers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pulse_q   <= '0;
            hold_q    <= '0;
            ack_cnt_q <= '0;
        end else begin
            pulse_q   <= pulse_d;
            hold_q    <= hold_d;
            ack_cnt_q <= ack_cnt_d;
        end
    end

    // Drop presses the controller already holds (press is still consumed);
    // the hold flag bridges the lamp until the controller shows the request.
    always_comb begin
        pulse_d   = rise_s & BTN_OK & ~req_all_s;
        hold_d    = hold_q;
        ack_cnt_d = ack_cnt_q;
        for (int b = 0; b < NB; b++) begin
            if (pulse_d[b]) begin
                hold_d[b]    = 1'b1;
                ack_cnt_d[b] = ACK_LOAD;
            end else if (hold_q[b] && (req_all_s[b] || (ack_cnt_q[b] == '0))) begin
                hold_d[b]    = 1'b0;
                ack_cnt_d[b] = '0;
            end else if (hold_q[b]) begin
                ack_cnt_d[b] = ack_cnt_q[b] - 1'b1;
            end else begin
                ack_cnt_d[b] = ack_cnt_q[b];
            end
        end
    end

    // Lamps are forced dark while reset is held, even if the controller is driving requests.
    assign lamp_s = reset ? ((req_all_s | hold_q) & BTN_OK) : '0;

    assign {in_down, in_up, in_eb}       = pulse_q;
    assign {lamp_down, lamp_up, lamp_eb} = lamp_s;

    // Floor indicator, last-valid-floor memory and chime FSM state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            floor_bin_q   <= '0;
            floor_valid_q <= 1'b0;
            last_bin_q    <= '0;
            have_last_q   <= 1'b0;
            state_q       <= IDLE;
            chime_cnt_q   <= '0;
        end else begin
            floor_bin_q   <= floor_bin_d;
            floor_valid_q <= floor_valid_d;
            last_bin_q    <= last_bin_d;
            have_last_q   <= have_last_d;
            state_q       <= state_d;
            chime_cnt_q   <= chime_cnt_d;
        end
    end

    // Floor decode and chime next-state; the first valid floor after reset
    // has nothing to compare against and so always chimes.
    always_comb begin
        floor_valid_d = is_onehot(q);
        if (floor_valid_d) begin
            floor_bin_d = onehot_index(q);
        end else begin
            floor_bin_d = floor_bin_q;
        end

        arrival_s = floor_valid_q && (!have_last_q || (floor_bin_q != last_bin_q));

        last_bin_d  = last_bin_q;
        have_last_d = have_last_q;
        if (floor_valid_q) begin
            last_bin_d  = floor_bin_q;
            have_last_d = 1'b1;
        end else begin
            last_bin_d  = last_bin_q;
            have_last_d = have_last_q;
        end

        state_d     = state_q;
        chime_cnt_d = chime_cnt_q;
        if (arrival_s) begin
            state_d     = RING;
            chime_cnt_d = CHIME_LOAD;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d     = IDLE;
                    chime_cnt_d = '0;
                end
                RING: begin
                    if (chime_cnt_q <= CW'(1)) begin
                        state_d     = IDLE;
                        chime_cnt_d = '0;
                    end else begin
                        state_d     = RING;
                        chime_cnt_d = chime_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    chime_cnt_d = '0;
                end
            endcase
        end
    end

    assign floor_bin   = floor_bin_q;
    assign floor_valid = floor_valid_q;
    assign chime       = (state_q == RING);

endmodule

// File: tb/tb_call_panel.sv
// Self-checking bench for call_panel: a cycle-level behavioural model is
// compared on every clock, plus directed scenarios with literal expectations.
module tb_call_panel;
    import elevator_pkg::*;

    localparam int F   = 8;
    localparam int DEB = 4;
    localparam int ACK = 4;
    localparam int CH  = 20;
    localparam int NB  = 3 * F;

    logic clk = 1'b0;
    logic reset;
    logic [F-1:0] btn_eb = '0, btn_up = '0, btn_down = '0;
    logic [F-1:0] q = '0, q_eb = '0, q_up = '0, q_down = '0;
    logic [F-1:0] in_eb, in_up, in_down, lamp_eb, lamp_up, lamp_down;
    logic [FLOOR_W-1:0] floor_bin;
    logic floor_valid, chime;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    call_panel #(
        .FLOORS(F), .DEBOUNCE_CYCLES(DEB), .ACK_CYCLES(ACK), .CHIME_CYCLES(CH)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_eb(btn_eb), .btn_up(btn_up), .btn_down(btn_down),
        .in_eb(in_eb), .in_up(in_up), .in_down(in_down),
        .q(q), .q_eb(q_eb), .q_up(q_up), .q_down(q_down),
        .lamp_eb(lamp_eb), .lamp_up(lamp_up), .lamp_down(lamp_down),
        .floor_bin(floor_bin), .floor_valid(floor_valid), .chime(chime)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // Button index b: 0..F-1 car, F..2F-1 hall-up, 2F..3F-1 hall-down.
    bit d1[NB], d2[NB], acc[NB], pend[NB];
    int run[NB], rem[NB];
    bit [NB-1:0] m_in;
    bit [NB-1:0] m_raw, m_req;
    bit m_fv, m_have;
    int m_fb, m_last, m_ring;

    function automatic bit usable(int b);
        return !((b == 2 * F - 1) || (b == 2 * F));
    endfunction

    // Model: a level seen two edges late must disagree with the accepted level
    // for DEB consecutive samples to be taken; a taken press is announced one
    // edge later unless the controller already has it.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < NB; b++) begin
                d1[b] = 0; d2[b] = 0; acc[b] = 0; pend[b] = 0; run[b] = 0; rem[b] = 0;
            end
            m_in = '0; m_fv = 0; m_have = 0; m_fb = 0; m_last = 0; m_ring = 0;
        end else begin
            m_raw = {btn_down, btn_up, btn_eb};
            m_req = {q_down, q_up, q_eb};
            for (int b = 0; b < NB; b++) begin
                if (d2[b] != acc[b]) run[b]++; else run[b] = 0;
                m_in[b] = pend[b] && usable(b) && !m_req[b];
                pend[b] = 0;
                if (run[b] == DEB) begin
                    acc[b] = d2[b]; run[b] = 0; pend[b] = d2[b];
                end
                d2[b] = d1[b];
                d1[b] = m_raw[b];
                if (m_in[b]) rem[b] = ACK;
                else if (rem[b] > 0) rem[b] = m_req[b] ? 0 : rem[b] - 1;
            end
            if (m_fv && (!m_have || m_fb != m_last)) m_ring = CH;
            else if (m_ring > 0) m_ring--;
            if (m_fv) begin m_last = m_fb; m_have = 1; end
            if ($countones(q) == 1) begin
                m_fv = 1;
                for (int i = 0; i < F; i++) if (q[i]) m_fb = i;
            end else begin
                m_fv = 0;
            end
        end
    end

    logic [NB-1:0] lamp_exp;
    logic [NB-1:0] req_now;

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        req_now = {q_down, q_up, q_eb};
        for (int b = 0; b < NB; b++)
            lamp_exp[b] = reset && usable(b) && (req_now[b] || rem[b] > 0);
        check("model_in", 32'({in_down, in_up, in_eb}), 32'(m_in));
        check("model_lamp", 32'({lamp_down, lamp_up, lamp_eb}), 32'(lamp_exp));
        check("model_floor_bin", 32'(floor_bin), 32'(m_fb));
        check("model_floor_valid", 32'(floor_valid), 32'(m_fv));
        check("model_chime", 32'(chime), 32'(m_ring > 0));
    end

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("rst_in", 32'({in_down, in_up, in_eb}), 32'd0);
        check("rst_lamp", 32'({lamp_down, lamp_up, lamp_eb}), 32'd0);
        check("rst_floor", 32'({floor_bin, floor_valid, chime}), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        edges(2);

        // clean press on car button 3
        @(negedge clk); btn_eb[3] = 1'b1;
        edges(6); check("press_early", 32'(in_eb), 32'h00);
        edges(1); check("press_pulse", 32'(in_eb), 32'h08);
        check("press_lamp", 32'(lamp_eb), 32'h08);
        edges(1); check("press_once", 32'(in_eb), 32'h00);
        check("press_lamp_hold", 32'(lamp_eb), 32'h08);
        @(negedge clk); q_eb[3] = 1'b1;
        edges(3); check("lamp_via_q", 32'(lamp_eb), 32'h08);
        @(negedge clk); btn_eb[3] = 1'b0; q_eb[3] = 1'b0;
        edges(12); check("press_done", 32'(lamp_eb), 32'h00);

        // bouncing hall-up button 2
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); btn_up[2] = (i % 2 == 0);
        end
        @(negedge clk); btn_up[2] = 1'b0;
        edges(12); check("bounce_lamp", 32'(lamp_up), 32'h00);

        // masked buttons and duplicate suppression
        @(negedge clk);
        q_down[5] = 1'b1; btn_up[7] = 1'b1; btn_down[0] = 1'b1; btn_down[5] = 1'b1;
        edges(10); check("dup_lamp", 32'(lamp_down), 32'h20);
        check("mask_lamp_up", 32'(lamp_up), 32'h00);
        @(negedge clk); q_down[5] = 1'b0;
        edges(1); check("dup_no_hold", 32'(lamp_down), 32'h00);
        @(negedge clk); btn_up[7] = 1'b0; btn_down[0] = 1'b0; btn_down[5] = 1'b0;
        edges(10);

        // acknowledge timeout on car button 6
        @(negedge clk); btn_eb[6] = 1'b1;
        edges(7); check("ack_pulse", 32'(in_eb), 32'h40);
        check("ack_lamp_first", 32'(lamp_eb), 32'h40);
        edges(3); check("ack_lamp_last", 32'(lamp_eb), 32'h40);
        edges(1); check("ack_timeout", 32'(lamp_eb), 32'h00);
        @(negedge clk); btn_eb[6] = 1'b0;
        edges(10);

        // floor decode and chime
        @(negedge clk); q = 8'h01;
        edges(1); check("floor0_bin", 32'(floor_bin), 32'd0);
        check("floor0_valid", 32'(floor_valid), 32'd1);
        check("floor0_chime_late", 32'(chime), 32'd0);
        edges(1); check("first_arrival", 32'(chime), 32'd1);
        edges(22); check("first_chime_end", 32'(chime), 32'd0);
        @(negedge clk); q = 8'h04;
        edges(1); check("floor2_bin", 32'(floor_bin), 32'd2);
        edges(1); check("floor2_chime", 32'(chime), 32'd1);
        edges(8);
        @(negedge clk); q = 8'h08;
        edges(1); check("floor3_bin", 32'(floor_bin), 32'd3);
        edges(11); check("chime_extended", 32'(chime), 32'd1);
        edges(9); check("chime_last", 32'(chime), 32'd1);
        edges(1); check("chime_end", 32'(chime), 32'd0);
        @(negedge clk); q = 8'h18;
        edges(1); check("multi_invalid", 32'(floor_valid), 32'd0);
        check("multi_hold_bin", 32'(floor_bin), 32'd3);
        @(negedge clk); q = 8'h08;
        edges(2); check("same_floor_no_chime", 32'(chime), 32'd0);

        // asynchronous reset mid-debounce and mid-chime
        @(negedge clk); q = 8'h10; btn_eb[1] = 1'b1;
        edges(4); check("pre_reset_chime", 32'(chime), 32'd1);
        @(negedge clk); reset = 1'b0;
        #1;
        check("async_in", 32'({in_down, in_up, in_eb}), 32'd0);
        check("async_lamp", 32'({lamp_down, lamp_up, lamp_eb}), 32'd0);
        check("async_floor", 32'({floor_bin, floor_valid}), 32'd0);
        check("async_chime", 32'(chime), 32'd0);
        @(negedge clk); reset = 1'b1;
        edges(6); check("repress_early", 32'(in_eb), 32'h00);
        edges(1); check("repress_pulse", 32'(in_eb), 32'h02);
        edges(1); check("repress_once", 32'(in_eb), 32'h00);
        @(negedge clk); btn_eb[1] = 1'b0; q = 8'h00;
        edges(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
